// File: rtl/ccff_bitstream_loader.sv
// Feeds bitstream words into parallel configuration chains, recirculates them once
// through the tails to check parity, then releases the fabric.
module ccff_bitstream_loader #(
  parameter int NUM_CHAINS = 10,
  parameter int CHAIN_LEN  = 4096,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clock,
  input  logic                  global_reset,
  input  logic                  start,
  input  logic [NUM_CHAINS-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  config_enable,
  output logic                  CFG_DONE,
  output logic                  busy,
  output logic                  cfg_error,
  output logic [CNT_W-1:0]      word_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] VERIFY = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;

  localparam logic [CNT_W-1:0] LEN    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);

  logic [2:0]            r_state;
  logic [NUM_CHAINS-1:0] r_head_q;
  logic                  r_shift_q;
  logic [NUM_CHAINS-1:0] r_acc_wr;
  logic [NUM_CHAINS-1:0] r_acc_rd;
  logic [CNT_W-1:0]      r_word_count;
  logic [CNT_W-1:0]      r_shift_cnt;
  logic                  r_cfg_error;

  logic                  w_in_verify;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_next_count;
  logic [NUM_CHAINS-1:0] w_acc_rd_next;

  assign w_in_verify   = (r_state == VERIFY);
  assign s_ready       = (r_state == LOAD);
  assign w_accept      = s_ready && s_valid;
  assign w_next_count  = (r_word_count == LEN) ? r_word_count : r_word_count + CNT_W'(1);
  assign w_acc_rd_next = r_acc_rd ^ ccff_tail;

  // During VERIFY the tail feeds straight back to the head so the loop stays CHAIN_LEN long.
  assign ccff_head     = w_in_verify ? ccff_tail : r_head_q;
  assign ccff_shift_en = w_in_verify | r_shift_q;
  assign config_enable = (r_state == DONE);
  assign CFG_DONE      = (r_state == DONE);
  assign busy          = (r_state == LOAD) || (r_state == DRAIN) || w_in_verify;
  assign cfg_error     = r_cfg_error;
  assign word_count    = r_word_count;

  always_ff @(posedge prog_clock or negedge global_reset) begin
    if (!global_reset) begin
      r_state      <= IDLE;
      r_head_q     <= '0;
      r_shift_q    <= 1'b0;
      r_acc_wr     <= '0;
      r_acc_rd     <= '0;
      r_word_count <= '0;
      r_shift_cnt  <= '0;
      r_cfg_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            r_state      <= LOAD;
            r_head_q     <= '0;
            r_shift_q    <= 1'b0;
            r_acc_wr     <= '0;
            r_acc_rd     <= '0;
            r_word_count <= '0;
            r_cfg_error  <= 1'b0;
          end
        end
        LOAD: begin
          r_shift_q <= w_accept;
          if (w_accept) begin
            r_head_q     <= s_data;
            r_acc_wr     <= r_acc_wr ^ s_data;
            r_word_count <= w_next_count;
            // Exactly CHAIN_LEN words with s_last on the final one; anything else is fatal.
            if (s_last && (w_next_count == LEN)) begin
              r_state <= DRAIN;
            end else if (s_last || (w_next_count == LEN)) begin
              r_state     <= ERROR;
              r_cfg_error <= 1'b1;
              r_shift_q   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          r_shift_q   <= 1'b0;
          r_shift_cnt <= '0;
          r_state     <= VERIFY;
        end
        VERIFY: begin
          r_acc_rd    <= w_acc_rd_next;
          r_shift_cnt <= r_shift_cnt + CNT_W'(1);
          if (r_shift_cnt == LEN_M1) begin
            if (w_acc_rd_next == r_acc_wr) begin
              r_state <= DONE;
            end else begin
              r_state     <= ERROR;
              r_cfg_error <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with a behavioural model of four 8-deep chains.
module tb_ccff_bitstream_loader;

  localparam int NC = 4;
  localparam int CL = 8;
  localparam int CW = $clog2(CL + 1);

  logic          clk = 1'b0;
  logic          globalReset;
  logic          start;
  logic [NC-1:0] sData;
  logic          sValid;
  logic          sLast;
  logic          sReady;
  logic [NC-1:0] ccffHead;
  logic [NC-1:0] ccffTail;
  logic          ccffShiftEn;
  logic          configEnable;
  logic          cfgDone;
  logic          busy;
  logic          cfgError;
  logic [CW-1:0] wordCount;

  logic [NC-1:0] chainMem [CL];
  logic [NC-1:0] faultMask = '0;

  int nCompared   = 0;
  int nMismatched = 0;

  ccff_bitstream_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .prog_clock   (clk),
    .global_reset (globalReset),
    .start        (start),
    .s_data       (sData),
    .s_valid      (sValid),
    .s_last       (sLast),
    .s_ready      (sReady),
    .ccff_head    (ccffHead),
    .ccff_tail    (ccffTail),
    .ccff_shift_en(ccffShiftEn),
    .config_enable(configEnable),
    .CFG_DONE     (cfgDone),
    .busy         (busy),
    .cfg_error    (cfgError),
    .word_count   (wordCount)
  );

  always #5 clk = ~clk;

  // Chain model: index 0 is nearest the head, index CL-1 drives the tail.
  assign ccffTail = chainMem[CL-1] ^ faultMask;

  always @(posedge clk) begin
    if (ccffShiftEn) begin
      for (int j = CL - 1; j > 0; j--) chainMem[j] <= chainMem[j-1];
      chainMem[0] <= ccffHead;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic st, input logic [NC-1:0] d, input logic v, input logic l);
    start  = st;
    sData  = d;
    sValid = v;
    sLast  = l;
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_s_ready"}, sReady, 0);
    checkOutput({tag, "_head"}, ccffHead, 0);
    checkOutput({tag, "_shift_en"}, ccffShiftEn, 0);
    checkOutput({tag, "_cfg_enable"}, configEnable, 0);
    checkOutput({tag, "_cfg_done"}, cfgDone, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_cfg_error"}, cfgError, 0);
    checkOutput({tag, "_word_count"}, wordCount, 0);
  endtask

  // Full-length load of words 1..8, optional stall gap, tail fault or mid-verify reset.
  task automatic runLoad(input string tag, input int gap, input int faultAt, input int resetAt);
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput({tag, "_start_busy"}, busy, 1);
    checkOutput({tag, "_start_ready"}, sReady, 1);
    checkOutput({tag, "_start_done"}, cfgDone, 0);
    checkOutput({tag, "_start_cfg_enable"}, configEnable, 0);
    checkOutput({tag, "_start_error"}, cfgError, 0);
    checkOutput({tag, "_start_count"}, wordCount, 0);
    for (int k = 1; k <= CL; k++) begin
      applyStimulus(1'b0, NC'(k), 1'b1, k == CL);
      cycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("%s_head_w%0d", tag, k), ccffHead, k);
      checkOutput($sformatf("%s_shift_w%0d", tag, k), ccffShiftEn, 1);
      checkOutput($sformatf("%s_count_w%0d", tag, k), wordCount, k);
      checkOutput($sformatf("%s_ready_w%0d", tag, k), sReady, (k < CL) ? 1 : 0);
      if (k < CL) begin
        for (int g = 0; g < gap; g++) begin
          cycle();
          checkOutput($sformatf("%s_stall_shift_w%0d", tag, k), ccffShiftEn, 0);
          checkOutput($sformatf("%s_stall_ready_w%0d", tag, k), sReady, 1);
        end
      end
    end
    checkOutput({tag, "_drain_busy"}, busy, 1);
    cycle();
    for (int j = 0; j < CL; j++) begin
      if (j == resetAt) begin
        #2 globalReset = 1'b0;
        #1;
        checkIdleOutputs({tag, "_async_reset"});
        @(negedge clk);
        globalReset = 1'b1;
        return;
      end
      if (j == faultAt) faultMask = 4'b0100;
      #1;
      checkOutput($sformatf("%s_verify_head_%0d", tag, j), ccffHead, (j + 1) ^ ((j == faultAt) ? 4 : 0));
      checkOutput($sformatf("%s_verify_shift_%0d", tag, j), ccffShiftEn, 1);
      cycle();
      faultMask = '0;
    end
    if (faultAt >= 0) begin
      checkOutput({tag, "_err_flag"}, cfgError, 1);
      checkOutput({tag, "_err_done"}, cfgDone, 0);
      checkOutput({tag, "_err_cfg_enable"}, configEnable, 0);
      checkOutput({tag, "_err_shift"}, ccffShiftEn, 0);
      checkOutput({tag, "_err_ready"}, sReady, 0);
    end else begin
      checkOutput({tag, "_done"}, cfgDone, 1);
      checkOutput({tag, "_cfg_enable"}, configEnable, 1);
      checkOutput({tag, "_done_shift"}, ccffShiftEn, 0);
      checkOutput({tag, "_done_busy"}, busy, 0);
      checkOutput({tag, "_done_error"}, cfgError, 0);
      checkOutput({tag, "_done_count"}, wordCount, CL);
      checkOutput({tag, "_chain_head_slot"}, chainMem[0], CL);
      checkOutput({tag, "_chain_tail_slot"}, chainMem[CL-1], 1);
    end
  endtask

  // Wrong-length bitstream: lastAt==0 means s_last is never asserted.
  task automatic runBadLoad(input string tag, input int numWords, input int lastAt);
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    cycle();
    for (int k = 1; k <= numWords; k++) begin
      applyStimulus(1'b0, NC'(k), 1'b1, k == lastAt);
      cycle();
    end
    checkOutput({tag, "_error"}, cfgError, 1);
    checkOutput({tag, "_done"}, cfgDone, 0);
    checkOutput({tag, "_ready"}, sReady, 0);
    checkOutput({tag, "_shift"}, ccffShiftEn, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_count"}, wordCount, numWords);
    applyStimulus(1'b0, 4'hF, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput({tag, "_ready_after"}, sReady, 0);
    checkOutput({tag, "_count_held"}, wordCount, numWords);
  endtask

  initial begin
    globalReset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    checkIdleOutputs("reset");
    globalReset = 1'b1;
    cycle();

    $display("[TB] nominal load");
    runLoad("nominal", 0, -1, -1);

    $display("[TB] load with stalls");
    runLoad("stall", 2, -1, -1);

    $display("[TB] short bitstream");
    runBadLoad("short", 5, 5);

    $display("[TB] long bitstream");
    runBadLoad("long", CL, 0);

    $display("[TB] readback fault then clean reload");
    runLoad("fault", 0, 3, -1);
    runLoad("reload", 0, -1, -1);

    $display("[TB] async reset mid-verify then reload");
    runLoad("midreset", 0, -1, 4);
    runLoad("after_reset", 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
